// File: rtl/dvs_packet_parser.sv
// Byte-stream framer for DVS event packets: HEADER, P0..P4, CK.
// Good packets become one push on the event FIFO interface; bad ones are counted and dropped.
module dvs_packet_parser #(
   parameter logic [7:0] HEADER         = 8'hA5,
   parameter int         X_MAX          = 320,
   parameter int         Y_MAX          = 320,
   parameter int         TIMEOUT_CYCLES = 1024,
   parameter int         CNT_W          = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   output logic             in_ready,
   output logic             push_valid,
   output logic [8:0]       push_x,
   output logic [8:0]       push_y,
   output logic             push_polarity,
   output logic [15:0]      push_ts,
   input  logic             push_ready,
   output logic [CNT_W-1:0] pkt_count,
   output logic [CNT_W-1:0] err_count,
   output logic             busy
);
   localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [9:0] X_LIM = 10'(X_MAX);
   localparam logic [9:0] Y_LIM = 10'(Y_MAX);

   typedef enum logic [1:0] {HUNT, PAYLOAD, CHECK, EMIT} state_t;

   state_t        state_q, state_d;
   logic [2:0]    idx_q;
   logic [7:0]    xor_q;
   logic [34:0]   pay_q;   // reserved bits [39:35] shift out the top
   logic [TW-1:0] tmo_q;

   logic xfer, tmo_hit, range_ok;
   logic load, bad, pushed, tmo_clr, tmo_inc;

   assign in_ready = rst && (state_q != EMIT);
   assign xfer     = in_valid && in_ready;
   assign busy     = (state_q != HUNT);
   assign tmo_hit  = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
   assign range_ok = ({1'b0, pay_q[34:26]} < X_LIM) && ({1'b0, pay_q[25:17]} < Y_LIM);

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      bad     = 1'b0;
      pushed  = 1'b0;
      tmo_clr = 1'b0;
      tmo_inc = 1'b0;
      case (state_q)
         HUNT: begin
            if (xfer && in_data == HEADER) begin
               state_d = PAYLOAD;
               tmo_clr = 1'b1;
            end
         end
         PAYLOAD: begin
            if (xfer) begin
               tmo_clr = 1'b1;
               if (idx_q == 3'd4) state_d = CHECK;
            end else if (tmo_hit) begin
               state_d = HUNT;
               bad     = 1'b1;
            end else begin
               tmo_inc = 1'b1;
            end
         end
         CHECK: begin
            if (xfer) begin
               tmo_clr = 1'b1;
               if (in_data == xor_q && range_ok) begin
                  state_d = EMIT;
                  load    = 1'b1;
               end else begin
                  state_d = HUNT;
                  bad     = 1'b1;
               end
            end else if (tmo_hit) begin
               state_d = HUNT;
               bad     = 1'b1;
            end else begin
               tmo_inc = 1'b1;
            end
         end
         EMIT: begin
            if (push_ready) begin
               state_d = HUNT;
               pushed  = 1'b1;
            end
         end
         default: state_d = HUNT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= HUNT;
         idx_q         <= '0;
         xor_q         <= '0;
         pay_q         <= '0;
         tmo_q         <= '0;
         push_valid    <= 1'b0;
         push_x        <= '0;
         push_y        <= '0;
         push_polarity <= 1'b0;
         push_ts       <= '0;
         pkt_count     <= '0;
         err_count     <= '0;
      end else begin
         state_q <= state_d;
         if (tmo_clr)      tmo_q <= '0;
         else if (tmo_inc) tmo_q <= tmo_q + TW'(1);

         if (state_q == HUNT && xfer) begin
            idx_q <= '0;
            xor_q <= '0;
         end else if (state_q == PAYLOAD && xfer) begin
            idx_q <= idx_q + 3'd1;
            xor_q <= xor_q ^ in_data;
            pay_q <= {pay_q[26:0], in_data};
         end

         if (load) begin
            push_valid    <= 1'b1;
            push_x        <= pay_q[34:26];
            push_y        <= pay_q[25:17];
            push_polarity <= pay_q[16];
            push_ts       <= pay_q[15:0];
         end else if (pushed) begin
            push_valid    <= 1'b0;
         end

         if (pushed && pkt_count != '1) pkt_count <= pkt_count + CNT_W'(1);
         if (bad && err_count != '1)    err_count <= err_count + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_dvs_packet_parser.sv
// Directed bench for dvs_packet_parser: stimulus queues expected events, a monitor
// pops and compares on every push handshake. A narrow-counter twin checks saturation.
module tb_dvs_packet_parser;
   localparam int T = 1024;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready, s_in_ready;
   logic        push_valid, s_push_valid;
   logic [8:0]  push_x, push_y, s_push_x, s_push_y;
   logic        push_polarity, s_push_polarity;
   logic [15:0] push_ts, s_push_ts;
   logic        push_ready;
   logic [15:0] pkt_count, err_count;
   logic [3:0]  s_pkt_count, s_err_count;
   logic        busy, s_busy;

   always #5 clk = ~clk;

   dvs_packet_parser #(.TIMEOUT_CYCLES(T)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .push_valid(push_valid), .push_x(push_x), .push_y(push_y),
      .push_polarity(push_polarity), .push_ts(push_ts), .push_ready(push_ready),
      .pkt_count(pkt_count), .err_count(err_count), .busy(busy));

   dvs_packet_parser #(.TIMEOUT_CYCLES(T), .CNT_W(4)) u_sat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(s_in_ready),
      .push_valid(s_push_valid), .push_x(s_push_x), .push_y(s_push_y),
      .push_polarity(s_push_polarity), .push_ts(s_push_ts), .push_ready(push_ready),
      .pkt_count(s_pkt_count), .err_count(s_err_count), .busy(s_busy));

   typedef struct packed {
      logic [8:0]  x;
      logic [8:0]  y;
      logic        pol;
      logic [15:0] ts;
   } ev_t;

   ev_t exp_q[$];
   int  n_vec = 0;
   int  n_mis = 0;

   localparam logic [55:0] PKT1   = 56'hA5_00_14_15_12_34_27;  // x=5 y=10 pol=1 ts=1234
   localparam logic [55:0] BADCK  = 56'hA5_00_14_15_12_34_28;
   localparam logic [55:0] XOVER  = 56'hA5_05_00_00_00_00_05;  // x=320
   localparam logic [55:0] YOVER  = 56'hA5_00_02_80_00_00_82;  // y=320
   localparam logic [55:0] EDGE   = 56'hA5_04_FE_7E_FF_FF_84;  // x=319 y=319 pol=0 ts=FFFF
   localparam logic [55:0] RSVD   = 56'hA5_F8_14_15_12_34_DF;  // reserved bits set, else PKT1
   localparam logic [55:0] HDRDAT = 56'hA5_00_00_00_A5_A5_00;  // header value inside payload

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic expect_ev(input logic [8:0] x, input logic [8:0] y, input logic pol,
                            input logic [15:0] ts);
      ev_t e;
      e.x = x; e.y = y; e.pol = pol; e.ts = ts;
      exp_q.push_back(e);
   endtask

   always @(negedge clk) begin
      if (rst && push_valid && push_ready) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_mis++;
            $display("FAIL unexpected_push: got x=%0d y=%0d ts=%0h expected none",
                     push_x, push_y, push_ts);
         end else begin
            ev_t e;
            e = exp_q.pop_front();
            chk("push_x", 32'(push_x), 32'(e.x));
            chk("push_y", 32'(push_y), 32'(e.y));
            chk("push_pol", 32'(push_polarity), 32'(e.pol));
            chk("push_ts", 32'(push_ts), 32'(e.ts));
         end
      end
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [7:0] b);
      logic ok;
      ok = 1'b0;
      in_valid = 1'b1;
      in_data  = b;
      for (int t = 0; t < 100 && !ok; t++) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!ok) chk("send_timeout", 32'(ok), 32'd1);
   endtask

   task automatic pkt(input logic [55:0] p);
      for (int i = 6; i >= 0; i--) send(p[i*8 +: 8]);
   endtask

   task automatic wait_idle();
      logic ok;
      ok = 1'b0;
      for (int t = 0; t < 50 && !ok; t++) begin
         @(negedge clk);
         ok = !busy;
         @(posedge clk);
         #1;
      end
      if (!ok) chk("idle_timeout", 32'(ok), 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic stable;
      rst = 1'b0; in_valid = 1'b0; in_data = '0; push_ready = 1'b1;
      tick(3);
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_push_valid", 32'(push_valid), 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);
      chk("post_rst_busy", 32'(busy), 32'd0);
      chk("post_rst_pkt", 32'(pkt_count), 32'd0);
      chk("post_rst_err", 32'(err_count), 32'd0);
      @(posedge clk); #1;

      // basic packet and one-cycle push latency
      expect_ev(9'd5, 9'd10, 1'b1, 16'h1234);
      pkt(PKT1);
      chk("latency_push_valid", 32'(push_valid), 32'd1);
      wait_idle();
      chk("t1_pkt", 32'(pkt_count), 32'd1);
      chk("t1_err", 32'(err_count), 32'd0);

      // bad checksum, then recovery
      pkt(BADCK);
      tick(2);
      chk("t2_err", 32'(err_count), 32'd1);
      chk("t2_busy", 32'(busy), 32'd0);
      expect_ev(9'd5, 9'd10, 1'b1, 16'h1234);
      pkt(PKT1);
      wait_idle();
      chk("t2_pkt", 32'(pkt_count), 32'd2);

      // range boundaries, reserved bits, header-valued data
      pkt(XOVER);
      pkt(YOVER);
      tick(2);
      chk("t3_err", 32'(err_count), 32'd3);
      expect_ev(9'd319, 9'd319, 1'b0, 16'hFFFF);
      pkt(EDGE);
      wait_idle();
      expect_ev(9'd5, 9'd10, 1'b1, 16'h1234);
      pkt(RSVD);
      wait_idle();
      expect_ev(9'd0, 9'd0, 1'b0, 16'hA5A5);
      pkt(HDRDAT);
      wait_idle();
      chk("t3_pkt", 32'(pkt_count), 32'd5);

      // backpressure: 20 stalled cycles with the next header waiting
      push_ready = 1'b0;
      expect_ev(9'd5, 9'd10, 1'b1, 16'h1234);
      pkt(PKT1);
      stable = 1'b1;
      in_valid = 1'b1; in_data = 8'hA5;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!(push_valid && !in_ready && push_x == 9'd5 && push_y == 9'd10 &&
               push_polarity && push_ts == 16'h1234)) stable = 1'b0;
         @(posedge clk); #1;
      end
      chk("t4_stable", 32'(stable), 32'd1);
      chk("t4_pkt_stalled", 32'(pkt_count), 32'd5);
      push_ready = 1'b1;
      expect_ev(9'd5, 9'd10, 1'b1, 16'h1234);
      pkt(PKT1);
      wait_idle();
      chk("t4_pkt", 32'(pkt_count), 32'd7);

      // inter-byte timeout boundary, then junk before header
      send(8'hA5); send(8'h00); send(8'h14);
      tick(T - 1);
      chk("t5_busy_before", 32'(busy), 32'd1);
      tick(1);
      chk("t5_busy_after", 32'(busy), 32'd0);
      chk("t5_err", 32'(err_count), 32'd4);
      send(8'h00); send(8'hFF);
      expect_ev(9'd5, 9'd10, 1'b1, 16'h1234);
      pkt(PKT1);
      wait_idle();
      chk("t5_err_junk", 32'(err_count), 32'd4);
      chk("t5_pkt", 32'(pkt_count), 32'd8);

      // reset mid-packet
      send(8'hA5); send(8'h00); send(8'h14); send(8'h15);
      rst = 1'b0;
      tick(2);
      @(negedge clk);
      chk("t6_in_ready_rst", 32'(in_ready), 32'd0);
      chk("t6_busy", 32'(busy), 32'd0);
      chk("t6_pkt", 32'(pkt_count), 32'd0);
      chk("t6_err", 32'(err_count), 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("t6_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      expect_ev(9'd5, 9'd10, 1'b1, 16'h1234);
      pkt(PKT1);
      wait_idle();
      chk("t6_pkt_after", 32'(pkt_count), 32'd1);

      // reset mid-EMIT drops the pending event
      push_ready = 1'b0;
      pkt(PKT1);
      chk("t6_emit_valid", 32'(push_valid), 32'd1);
      rst = 1'b0;
      tick(1);
      @(negedge clk);
      chk("t6_emit_rst_valid", 32'(push_valid), 32'd0);
      chk("t6_emit_rst_ts", 32'(push_ts), 32'd0);
      chk("t6_emit_rst_x", 32'(push_x), 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      push_ready = 1'b1;
      tick(1);

      // saturation: narrow twin must stick at all-ones
      for (int i = 0; i < 18; i++) pkt(BADCK);
      tick(2);
      chk("sat_err_main", 32'(err_count), 32'd18);
      chk("sat_err_twin", 32'(s_err_count), 32'hF);
      for (int i = 0; i < 17; i++) begin
         expect_ev(9'd5, 9'd10, 1'b1, 16'h1234);
         pkt(PKT1);
         wait_idle();
      end
      chk("sat_pkt_main", 32'(pkt_count), 32'd17);
      chk("sat_pkt_twin", 32'(s_pkt_count), 32'hF);
      chk("sat_err_twin_hold", 32'(s_err_count), 32'hF);

      tick(3);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end
endmodule
